uart_rx_param: RTL

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It adds configurable frame format, oversampled majority-vote sampling, parity, framing, overrun and break detection, and a ready/valid output. It sits between the pad-side asynchronous rx line and a consumer, typically a FIFO or a register-bank RX holding register.

---
 rtl/uart_rx_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled majority-vote bit decisions,
// optional parity, 1 or 2 stop bits, break/framing/overrun flags and ready/valid output.
module uart_rx_param #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun
);

   localparam int TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
   localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SMP_W    = $clog2(OVERSAMPLE);
   localparam int MID      = OVERSAMPLE / 2;

   generate
      if (TICK_RAW < 1) begin : g_bad_tick
         $error("uart_rx_param: clock too slow for BAUD_RATE*OVERSAMPLE");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
          STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
         $error("uart_rx_param: illegal frame configuration");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_t;

   // Returns 1 when the received parity bit disagrees with the data word.
   function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic pb);
      case (PARITY)
         1:       parity_err_f = ~(^d ^ pb);
         2:       parity_err_f = ^d ^ pb;
         default: parity_err_f = 1'b0;
      endcase
   endfunction

   logic                 sync1_r, sync2_r, rx_s;
   logic [DIV_W-1:0]     div_cnt_r;
   logic                 tick_s;
   state_t               state_r;
   logic [SMP_W-1:0]     samp_cnt_r;
   logic                 s_lo_r, s_mid_r;
   logic [3:0]           bit_idx_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_bit_r, stop_idx_r, stop0_r, stop_low_r;
   logic                 maj_s, dec_s, end_s, complete_s, xfer_s;
   logic                 stop0_s, new_ferr_s, new_brk_s, new_perr_s;

   assign rx_s = sync2_r;

   // Two-flop synchroniser for the asynchronous line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

   // Free-running oversample tick divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   // Bit decision, frame completion and the error flags of the completing frame.
   always_comb begin
      tick_s     = (div_cnt_r == DIV_W'(TICK_DIV - 1));
      maj_s      = (s_lo_r & s_mid_r) | (s_lo_r & rx_s) | (s_mid_r & rx_s);
      dec_s      = tick_s && (samp_cnt_r == SMP_W'(MID + 1));
      end_s      = tick_s && (samp_cnt_r == SMP_W'(OVERSAMPLE - 1));
      complete_s = dec_s && (state_r == ST_STOP) && (stop_idx_r == 1'(STOP_BITS - 1));
      stop0_s    = (stop_idx_r == 1'b0) ? maj_s : stop0_r;
      new_ferr_s = stop_low_r | ~maj_s;
      new_brk_s  = (shift_r == {DATA_BITS{1'b0}}) && ((PARITY == 0) || !par_bit_r) && !stop0_s;
      new_perr_s = parity_err_f(shift_r, par_bit_r);
      xfer_s     = rx_valid && rx_ready;
   end

   // Frame receive state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         samp_cnt_r <= {SMP_W{1'b0}};
         s_lo_r     <= 1'b1;
         s_mid_r    <= 1'b1;
         bit_idx_r  <= 4'd0;
         shift_r    <= {DATA_BITS{1'b0}};
         par_bit_r  <= 1'b0;
         stop_idx_r <= 1'b0;
         stop0_r    <= 1'b1;
         stop_low_r <= 1'b0;
      end else begin
         if (tick_s && state_r != ST_IDLE) begin
            samp_cnt_r <= end_s ? {SMP_W{1'b0}} : samp_cnt_r + {{(SMP_W-1){1'b0}}, 1'b1};
            if (samp_cnt_r == SMP_W'(MID - 1)) s_lo_r  <= rx_s;
            if (samp_cnt_r == SMP_W'(MID))     s_mid_r <= rx_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (tick_s && !rx_s) begin
                  state_r    <= ST_START;
                  samp_cnt_r <= {SMP_W{1'b0}};
               end
            end
            ST_START: begin
               if (dec_s && maj_s) begin
                  state_r <= ST_IDLE;
               end else if (end_s) begin
                  state_r   <= ST_DATA;
                  bit_idx_r <= 4'd0;
               end
            end
            ST_DATA: begin
               if (dec_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
               if (end_s) begin
                  if (bit_idx_r == 4'(DATA_BITS - 1)) begin
                     state_r    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                     stop_idx_r <= 1'b0;
                     stop_low_r <= 1'b0;
                  end else begin
                     bit_idx_r <= bit_idx_r + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (dec_s) par_bit_r <= maj_s;
               if (end_s) begin
                  state_r    <= ST_STOP;
                  stop_idx_r <= 1'b0;
                  stop_low_r <= 1'b0;
               end
            end
            ST_STOP: begin
               // The frame finishes at the last stop-bit decision, not at the end of the bit.
               if (complete_s) begin
                  state_r <= new_ferr_s ? ST_WAIT_IDLE : ST_IDLE;
               end else if (dec_s) begin
                  stop0_r    <= maj_s;
                  stop_low_r <= ~maj_s;
               end else if (end_s) begin
                  stop_idx_r <= 1'b1;
               end
            end
            ST_WAIT_IDLE: begin
               if (tick_s && rx_s) state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Output holding register, handshake and sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= {DATA_BITS{1'b0}};
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (complete_s && (!rx_valid || xfer_s)) begin
            rx_data    <= shift_r;
            rx_valid   <= 1'b1;
            parity_err <= new_perr_s;
            frame_err  <= new_ferr_s;
            break_det  <= new_brk_s;
         end else if (xfer_s) begin
            rx_valid <= 1'b0;
         end
         if (complete_s && rx_valid && !xfer_s) begin
            overrun <= 1'b1;
         end else if (xfer_s) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule
